csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Sequencer and arbiter in front of the single-write-port CSR register file.
- Serialises trap entry (mepc, mcause, mtval, mstatus updates) and mret (mstatus restore) as multi-cycle write sequences, then issues a PC redirect.
- Arbitrates the CSR port between those sequences and the pipeline's CSR-instruction accesses. Sits between the execute/commit stage and the CSR register file.

Parameters:
- XLEN, 64, data width of CSR values and PCs.
- ADDR_W, 12, CSR address width (csr_addr_t).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- trap_req  in  1  level; exception/interrupt pending at commit.
- trap_cause  in  XLEN  mcause value; bit 63 set means interrupt.
- trap_pc  in  XLEN  faulting PC, written to mepc.
- trap_tval  in  XLEN  mtval value.
- mret_req  in  1  level; mret at commit.
- trap_ack  out  1  one-cycle pulse when trap_req or mret_req is accepted.
- pipe_csr_addr  in  ADDR_W  pipeline CSR address.
- pipe_csr_wdata  in  XLEN  pipeline CSR write data.
- pipe_csr_we  in  1  pipeline CSR write enable.
- pipe_csr_ready  out  1  pipeline access is granted this cycle.
- pipe_csr_rdata  out  XLEN  read data returned to the pipeline.
- csr_addr  out  ADDR_W  to CSR file.
- csr_wdata  out  XLEN  to CSR file.
- csr_we  out  1  to CSR file.
- csr_rdata  in  XLEN  from CSR file.
- mstatus_in  in  XLEN  current mstatus from CSR file.
- mtvec_in  in  XLEN  current mtvec from CSR file.
- mepc_in  in  XLEN  current mepc from CSR file.
- busy  out  1  sequencer is not IDLE; pipeline must stall.
- redirect_valid  out  1  one-cycle pulse; fetch jumps to redirect_pc.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state=IDLE; all latched registers 0; trap_ack=0, csr_we=0, busy=0, redirect_valid=0, redirect_pc=0.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_STATUS, REDIR.
- IDLE priority, highest first: trap_req, then mret_req, then pipeline access.
  - trap_req=1: latch cause, pc and tval; pulse trap_ack; go to T_EPC. Drop pipe_csr_we (csr_we=0, pipe_csr_ready=0); the trapping instruction's CSR write must not commit.
  - mret_req=1 (trap_req=0): pulse trap_ack; go to M_STATUS; suppress the pipeline write the same way.
  - Neither set: combinational pass-through. csr_addr=pipe_csr_addr, csr_wdata=pipe_csr_wdata, csr_we=pipe_csr_we, pipe_csr_ready=1.
- pipe_csr_rdata = csr_rdata in all states.
- Trap write sequence, one write per cycle:
  - T_EPC: write mepc = latched pc.
  - T_CAUSE: write mcause = latched cause.
  - T_TVAL: write mtval = latched tval.
  - T_STATUS: write mstatus = mstatus_in with MPIE(bit 7) = MIE(bit 3), MIE = 0, MPP[12:11] = 2'b11. Go to REDIR.
- mret: in M_STATUS write mstatus = mstatus_in with MIE = MPIE, MPIE = 1, MPP = 2'b00. Go to REDIR.
- REDIR: redirect_valid=1 for one cycle, csr_we=0, then back to IDLE.
  - Trap target: mtvec_in with bits [1:0] cleared.
  - mret target: mepc_in.
- Latency: trap accepted at cycle T → writes at T+1..T+4, redirect at T+5, IDLE at T+6. mret accepted at T → write at T+1, redirect at T+2.
- busy=1 in every state except IDLE. pipe_csr_ready=0 whenever busy.
- trap_req/mret_req while busy are ignored, with no ack. The requester holds the level until trap_ack and deasserts it the cycle after.
- Reset mid-sequence: return to IDLE immediately, no redirect, no further writes.
- Arithmetic: all XLEN-wide. Vector offset truncates to XLEN; no overflow detection.

Optional Feature:
- Macro: CSR_TRAP_VECTORED_EN.
- Defined: in REDIR for a trap, if mtvec_in[1:0]==2'b01 and latched cause bit 63 = 1, redirect_pc = {mtvec_in[63:2],2'b00} + 4*cause[5:0]. Otherwise the base address is used.
- Undefined: mtvec mode bits are ignored and redirect_pc is always the base.
- mret behaviour is identical in both builds.

Test Plan:
- Pass-through: IDLE, pipe write addr 0x340, wdata 0xDEAD → csr_we=1 and csr_addr=0x340 the same cycle; pipe_csr_ready=1; later read of 0x340 returns 0xDEAD.
- Trap entry:
  - Stimulus: mstatus=0x8, mtvec=0x8000_0100, trap_req with cause=2, pc=0x8000_0040, tval=0x13.
  - Writes: mepc=0x8000_0040 (T+1), mcause=2 (T+2), mtval=0x13 (T+3), mstatus=0x1880 (T+4).
  - Redirect: redirect_pc=0x8000_0100 at T+5; busy=1 from T+1 to T+5.
- mret: mstatus=0x1880, mepc=0x8000_0044 → mstatus written 0x88 at T+1; redirect_pc=0x8000_0044 at T+2.
- Collision: trap_req and pipe_csr_we (addr 0x340, data 0x55) in the same cycle → pipe write dropped, mscratch unchanged, trap sequence runs. trap_req and mret_req together → trap wins.
- Busy lockout and reset: mret_req during T_CAUSE → no ack, ignored. reset asserted in T_TVAL → IDLE next cycle, no redirect, busy=0.
- Vectored (CSR_TRAP_VECTORED_EN): mtvec=0x8000_0101, cause=0x8000_0000_0000_0007 → redirect_pc=0x8000_011C. Without the macro → 0x8000_0100.

Source files
------------

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: serialises trap/mret CSR write sequences and arbitrates the CSR write port; CSR_TRAP_VECTORED_EN enables vectored interrupt redirect.
module csr_trap_seq #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic              mret_req,
  output logic              trap_ack,
  input  logic [ADDR_W-1:0] pipe_csr_addr,
  input  logic [XLEN-1:0]   pipe_csr_wdata,
  input  logic              pipe_csr_we,
  output logic              pipe_csr_ready,
  output logic [XLEN-1:0]   pipe_csr_rdata,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_we,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [XLEN-1:0]   mstatus_in,
  input  logic [XLEN-1:0]   mtvec_in,
  input  logic [XLEN-1:0]   mepc_in,
  output logic              busy,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);
  typedef logic [ADDR_W-1:0] csr_addr_t;
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_STATUS, REDIR} state_t;
  localparam csr_addr_t MSTATUS = csr_addr_t'(12'h300);
  localparam csr_addr_t MEPC    = csr_addr_t'(12'h341);
  localparam csr_addr_t MCAUSE  = csr_addr_t'(12'h342);
  localparam csr_addr_t MTVAL   = csr_addr_t'(12'h343);
  state_t state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d;
  logic is_trap_q, is_trap_d;
  logic [XLEN-1:0] trap_status, mret_status, tvec_base, trap_target;
  always_comb begin
    trap_status = mstatus_in;
    trap_status[7] = mstatus_in[3];
    trap_status[3] = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status = mstatus_in;
    mret_status[3] = mstatus_in[7];
    mret_status[7] = 1'b1;
    mret_status[12:11] = 2'b00;
  end
  assign tvec_base = mtvec_in & ~XLEN'(3);
`ifdef CSR_TRAP_VECTORED_EN
  assign trap_target = (mtvec_in[1:0] == 2'b01 && cause_q[XLEN-1])
                     ? tvec_base + XLEN'({cause_q[5:0], 2'b00}) : tvec_base;
`else
  assign trap_target = tvec_base;
`endif
  assign busy = state_q != IDLE;
  assign pipe_csr_rdata = csr_rdata;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d = pc_q;
    tval_d = tval_q;
    is_trap_d = is_trap_q;
    trap_ack = 1'b0;
    csr_addr = pipe_csr_addr;
    csr_wdata = pipe_csr_wdata;
    csr_we = 1'b0;
    pipe_csr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          trap_ack = 1'b1;
          cause_d = trap_cause;
          pc_d = trap_pc;
          tval_d = trap_tval;
          is_trap_d = 1'b1;
          state_d = T_EPC;
        end else if (mret_req) begin
          trap_ack = 1'b1;
          is_trap_d = 1'b0;
          state_d = M_STATUS;
        end else begin
          csr_we = pipe_csr_we;
          pipe_csr_ready = 1'b1;
        end
      end
      T_EPC: begin
        csr_we = 1'b1;
        csr_addr = MEPC;
        csr_wdata = pc_q;
        state_d = T_CAUSE;
      end
      T_CAUSE: begin
        csr_we = 1'b1;
        csr_addr = MCAUSE;
        csr_wdata = cause_q;
        state_d = T_TVAL;
      end
      T_TVAL: begin
        csr_we = 1'b1;
        csr_addr = MTVAL;
        csr_wdata = tval_q;
        state_d = T_STATUS;
      end
      T_STATUS: begin
        csr_we = 1'b1;
        csr_addr = MSTATUS;
        csr_wdata = trap_status;
        state_d = REDIR;
      end
      M_STATUS: begin
        csr_we = 1'b1;
        csr_addr = MSTATUS;
        csr_wdata = mret_status;
        state_d = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc = is_trap_q ? trap_target : mepc_in;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q <= '0;
      tval_q <= '0;
      is_trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q <= pc_d;
      tval_q <= tval_d;
      is_trap_q <= is_trap_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_seq.sv
// tb_csr_trap_seq: directed vectors for csr_trap_seq with a small CSR file model behind the write port.
module tb_csr_trap_seq;
  logic clk = 1'b0;
  logic reset;
  logic trap_req, mret_req, trap_ack;
  logic [63:0] trap_cause, trap_pc, trap_tval;
  logic [11:0] pipe_csr_addr, csr_addr;
  logic [63:0] pipe_csr_wdata, pipe_csr_rdata, csr_wdata, csr_rdata;
  logic pipe_csr_we, pipe_csr_ready, csr_we, busy, redirect_valid;
  logic [63:0] mstatus_in, mtvec_in, mepc_in, redirect_pc;
  logic [63:0] csr_mem [4096];
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] vec_exp;

  always #5 clk = ~clk;

  always @(posedge clk) if (csr_we) csr_mem[csr_addr] <= csr_wdata;
  assign csr_rdata = csr_mem[csr_addr];

  csr_trap_seq dut (
    .clk(clk), .reset(reset),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .trap_ack(trap_ack),
    .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_we(pipe_csr_we),
    .pipe_csr_ready(pipe_csr_ready), .pipe_csr_rdata(pipe_csr_rdata),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
    .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    trap_req = 1'b0; mret_req = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    pipe_csr_addr = '0; pipe_csr_wdata = '0; pipe_csr_we = 1'b0;
    mstatus_in = '0; mtvec_in = '0; mepc_in = '0;
    nxt; nxt;
    reset = 1'b0;
    mid;
    chk("rst_busy", busy, 0);
    chk("rst_ack", trap_ack, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_ready", pipe_csr_ready, 1);

    // pass-through write to mscratch, then read it back
    nxt;
    pipe_csr_addr = 12'h340; pipe_csr_wdata = 64'hDEAD; pipe_csr_we = 1'b1;
    mid;
    chk("pt_we", csr_we, 1);
    chk("pt_addr", csr_addr, 64'h340);
    chk("pt_wdata", csr_wdata, 64'hDEAD);
    chk("pt_ready", pipe_csr_ready, 1);
    nxt;
    pipe_csr_we = 1'b0;
    mid;
    chk("pt_rd", pipe_csr_rdata, 64'hDEAD);

    // trap entry colliding with a pipeline write to mscratch
    nxt;
    mstatus_in = 64'h8; mtvec_in = 64'h8000_0100; mepc_in = 64'h1234;
    trap_req = 1'b1; trap_cause = 64'd2; trap_pc = 64'h8000_0040; trap_tval = 64'h13;
    pipe_csr_we = 1'b1; pipe_csr_addr = 12'h340; pipe_csr_wdata = 64'h55;
    mid;
    chk("tr_ack", trap_ack, 1);
    chk("tr_we0", csr_we, 0);
    chk("tr_rdy0", pipe_csr_ready, 0);
    nxt;
    trap_req = 1'b0;
    mid;
    chk("tr1_busy", busy, 1);
    chk("tr1_rdy", pipe_csr_ready, 0);
    chk("tr1_ack", trap_ack, 0);
    chk("tr1_we", csr_we, 1);
    chk("tr1_addr", csr_addr, 64'h341);
    chk("tr1_data", csr_wdata, 64'h8000_0040);
    nxt; mid;
    chk("tr2_addr", csr_addr, 64'h342);
    chk("tr2_data", csr_wdata, 64'd2);
    nxt; mid;
    chk("tr3_addr", csr_addr, 64'h343);
    chk("tr3_data", csr_wdata, 64'h13);
    nxt; mid;
    chk("tr4_addr", csr_addr, 64'h300);
    chk("tr4_data", csr_wdata, 64'h1880);
    chk("tr4_rv", redirect_valid, 0);
    nxt; mid;
    chk("tr5_rv", redirect_valid, 1);
    chk("tr5_rpc", redirect_pc, 64'h8000_0100);
    chk("tr5_we", csr_we, 0);
    chk("tr5_busy", busy, 1);
    nxt;
    pipe_csr_we = 1'b0;
    mid;
    chk("tr6_busy", busy, 0);
    chk("tr6_rv", redirect_valid, 0);
    chk("tr6_mscratch", pipe_csr_rdata, 64'hDEAD);
    chk("tr6_mepc_mem", csr_mem[12'h341], 64'h8000_0040);

    // mret
    nxt;
    mstatus_in = 64'h1880; mepc_in = 64'h8000_0044; mret_req = 1'b1;
    mid;
    chk("mr_ack", trap_ack, 1);
    chk("mr_busy0", busy, 0);
    nxt;
    mret_req = 1'b0;
    mid;
    chk("mr1_we", csr_we, 1);
    chk("mr1_addr", csr_addr, 64'h300);
    chk("mr1_data", csr_wdata, 64'h88);
    nxt; mid;
    chk("mr2_rv", redirect_valid, 1);
    chk("mr2_rpc", redirect_pc, 64'h8000_0044);
    nxt; mid;
    chk("mr3_busy", busy, 0);

    // trap and mret together: trap wins
    nxt;
    mstatus_in = 64'h8; mtvec_in = 64'h8000_0200; mepc_in = 64'h9999_0000;
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 64'd5; trap_pc = 64'h8000_0080; trap_tval = 64'h0;
    mid;
    chk("tm_ack", trap_ack, 1);
    nxt;
    trap_req = 1'b0; mret_req = 1'b0;
    mid;
    chk("tm1_addr", csr_addr, 64'h341);
    nxt; nxt; nxt; nxt; mid;
    chk("tm5_rv", redirect_valid, 1);
    chk("tm5_rpc", redirect_pc, 64'h8000_0200);
    nxt; mid;
    chk("tm6_busy", busy, 0);

    // busy lockout in T_CAUSE, then reset in T_TVAL
    nxt;
    trap_req = 1'b1; trap_cause = 64'd3; trap_pc = 64'h100; trap_tval = 64'h7;
    mid;
    nxt;
    trap_req = 1'b0;
    nxt;
    mret_req = 1'b1;
    mid;
    chk("lk_addr", csr_addr, 64'h342);
    chk("lk_ack", trap_ack, 0);
    nxt;
    mret_req = 1'b0;
    mid;
    chk("lk_tval", csr_addr, 64'h343);
    reset = 1'b1;
    nxt;
    reset = 1'b0;
    mid;
    chk("rs_busy", busy, 0);
    chk("rs_rv", redirect_valid, 0);
    chk("rs_we", csr_we, 0);
    chk("rs_ack", trap_ack, 0);
    nxt; mid;
    chk("rs2_rv", redirect_valid, 0);
    chk("rs2_busy", busy, 0);

    // vectored interrupt
`ifdef CSR_TRAP_VECTORED_EN
    vec_exp = 64'h8000_011C;
`else
    vec_exp = 64'h8000_0100;
`endif
    nxt;
    mtvec_in = 64'h8000_0101; mstatus_in = 64'h8;
    trap_req = 1'b1; trap_cause = 64'h8000_0000_0000_0007; trap_pc = 64'h200; trap_tval = 64'h0;
    mid;
    nxt;
    trap_req = 1'b0;
    nxt; nxt; nxt; nxt; mid;
    chk("vec_rv", redirect_valid, 1);
    chk("vec_rpc", redirect_pc, vec_exp);
    nxt; mid;
    chk("vec_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
